// File: rtl/pipe_adder_pkg.sv
// Shared configuration for the pipelined adder: default geometry and chunk-width helpers.
package pipe_adder_pkg;

    localparam int DEF_D_N    = 32;
    localparam int DEF_STAGES = 4;

    function automatic int ch_w(input int d_n, input int stages);
        return d_n / stages;
    endfunction

    // Legal geometry: at least one stage, no empty chunks, equal chunk widths.
    function automatic bit cfg_ok(input int d_n, input int stages);
        return (stages >= 1) && (stages <= d_n) && ((d_n % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// One carry-chain chunk: W-bit add with carry in/out; with PIPE_ADDER_OVF_EN it also
// exposes the carry into its MSB so the top chunk can flag signed overflow.
module adder_chunk
    import pipe_adder_pkg::*;
#(
    parameter int W = ch_w(DEF_D_N, DEF_STAGES)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic         cmsb
`endif
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign cout = full[W];

`ifdef PIPE_ADDER_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit.
    assign cmsb = a[W-1] ^ b[W-1] ^ sum[W-1];
`endif

endmodule

// File: rtl/pipe_adder.sv
// Pipelined D_N-bit adder/subtractor, one carry chunk per register stage, valid/ready on both ends.
// Optional signed-overflow output w_ovf when PIPE_ADDER_OVF_EN is defined.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int D_N    = DEF_D_N,
    parameter int STAGES = DEF_STAGES
) (
    input  logic           w_clk,
    input  logic           w_rst_n,
    input  logic           w_in_valid,
    output logic           w_in_ready,
    input  logic [D_N-1:0] w_a,
    input  logic [D_N-1:0] w_b,
    input  logic           w_sub,
    output logic           w_out_valid,
    input  logic           w_out_ready,
    output logic [D_N-1:0] w_s,
    output logic           w_cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic           w_ovf
`endif
);

    localparam int CH_W = ch_w(D_N, STAGES);

    if (!cfg_ok(D_N, STAGES)) begin : g_cfg_err
        $error("pipe_adder: D_N must be a multiple of STAGES and 1 <= STAGES <= D_N");
    end

    logic                       en;
    logic [D_N-1:0]             b_eff;
    logic [D_N-1:0]             a_d [STAGES];
    logic [D_N-1:0]             a_q [STAGES];
    logic [D_N-1:0]             b_d [STAGES];
    logic [D_N-1:0]             b_q [STAGES];
    logic [D_N-1:0]             s_d [STAGES];
    logic [D_N-1:0]             s_q [STAGES];
    logic [STAGES-1:0]          c_d, c_q;
    logic [STAGES-1:0]          vld_d, vld_q;
    logic [STAGES-1:0][CH_W-1:0] ch_sum;
    logic [STAGES-1:0]          ch_cout;
    logic [STAGES-1:0]          ch_cmsb;
    logic                       unused_bits;

    // A stalled output freezes the whole pipe, bubbles included.
    assign en         = ~vld_q[STAGES-1] | w_out_ready;
    assign w_in_ready = en;
    assign b_eff      = w_sub ? ~w_b : w_b;

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        if (k == 0) begin : g_first
            adder_chunk #(.W(CH_W)) u_chunk (
                .a   (w_a[CH_W-1:0]),
                .b   (b_eff[CH_W-1:0]),
                .cin (w_sub),
                .sum (ch_sum[k]),
                .cout(ch_cout[k])
`ifdef PIPE_ADDER_OVF_EN
                ,
                .cmsb(ch_cmsb[k])
`endif
            );
        end else begin : g_next
            adder_chunk #(.W(CH_W)) u_chunk (
                .a   (a_q[k-1][k*CH_W +: CH_W]),
                .b   (b_q[k-1][k*CH_W +: CH_W]),
                .cin (c_q[k-1]),
                .sum (ch_sum[k]),
                .cout(ch_cout[k])
`ifdef PIPE_ADDER_OVF_EN
                ,
                .cmsb(ch_cmsb[k])
`endif
            );
        end
    end

`ifndef PIPE_ADDER_OVF_EN
    assign ch_cmsb = '0;
`endif

    always_comb begin
        a_d[0]             = w_a;
        b_d[0]             = b_eff;
        s_d[0]             = '0;
        s_d[0][CH_W-1:0]   = ch_sum[0];
        c_d                = '0;
        c_d[0]             = ch_cout[0];
        vld_d              = '0;
        vld_d[0]           = w_in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]                   = a_q[k-1];
            b_d[k]                   = b_q[k-1];
            s_d[k]                   = s_q[k-1];
            s_d[k][k*CH_W +: CH_W]   = ch_sum[k];
            c_d[k]                   = ch_cout[k];
            vld_d[k]                 = vld_q[k-1];
        end
    end

    // Stage registers: chunk k result joins the lower sums already computed.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q   <= '0;
            vld_q <= '0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q   <= c_d;
            vld_q <= vld_d;
        end
    end

    assign w_out_valid = vld_q[STAGES-1];
    assign w_s         = s_q[STAGES-1];
    assign w_cout      = c_q[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    assign ovf_d = ch_cmsb[STAGES-1] ^ ch_cout[STAGES-1];

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign w_ovf = ovf_q;
`endif

    // Last-stage operands and the chunk-local MSB carries below the top chunk are never consumed.
    assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], ch_cmsb};

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: vector table, streaming, backpressure, mid-flight reset,
// and two extra geometries (8/1 and 64/8). Checks w_ovf when PIPE_ADDER_OVF_EN is defined.
module tb_pipe_adder;

    localparam int D_N    = 32;
    localparam int STAGES = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b1, sub = 1'b0;
    logic          in_ready, out_valid, cout;
    logic [31:0]   a = '0, b = '0, s;
    logic          v8 = 1'b0, sub8 = 1'b0, rdy8, ov8, c8;
    logic [7:0]    a8 = '0, b8 = '0, s8;
    logic          v64 = 1'b0, sub64 = 1'b0, rdy64, ov64, c64;
    logic [63:0]   a64 = '0, b64 = '0, s64;
    logic          one = 1'b1;
`ifdef PIPE_ADDER_OVF_EN
    logic          ovf, ovf8, ovf64;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_adder #(.D_N(D_N), .STAGES(STAGES)) dut (
        .w_clk(clk), .w_rst_n(rst_n), .w_in_valid(in_valid), .w_in_ready(in_ready),
        .w_a(a), .w_b(b), .w_sub(sub), .w_out_valid(out_valid), .w_out_ready(out_ready),
        .w_s(s), .w_cout(cout)
`ifdef PIPE_ADDER_OVF_EN
        , .w_ovf(ovf)
`endif
    );

    pipe_adder #(.D_N(8), .STAGES(1)) dut8 (
        .w_clk(clk), .w_rst_n(rst_n), .w_in_valid(v8), .w_in_ready(rdy8),
        .w_a(a8), .w_b(b8), .w_sub(sub8), .w_out_valid(ov8), .w_out_ready(one),
        .w_s(s8), .w_cout(c8)
`ifdef PIPE_ADDER_OVF_EN
        , .w_ovf(ovf8)
`endif
    );

    pipe_adder #(.D_N(64), .STAGES(8)) dut64 (
        .w_clk(clk), .w_rst_n(rst_n), .w_in_valid(v64), .w_in_ready(rdy64),
        .w_a(a64), .w_b(b64), .w_sub(sub64), .w_out_valid(ov64), .w_out_ready(one),
        .w_s(s64), .w_cout(c64)
`ifdef PIPE_ADDER_OVF_EN
        , .w_ovf(ovf64)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: unsigned compare gives the no-borrow flag for subtraction.
    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic op);
        if (op) return {(x >= y), x - y};
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic one_xfer(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; a = v.a; b = v.b; sub = v.sub;
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'b1;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, STAGES);
        chk({tag, "_s"}, s, v.s);
        chk({tag, "_cout"}, cout, v.cout);
`ifdef PIPE_ADDER_OVF_EN
        chk({tag, "_ovf"}, ovf, v.ovf);
`endif
        @(negedge clk);
        chk({tag, "_valid_drop"}, out_valid, 0);
    endtask

    task automatic run_stream(input int n, input int stall_at, input int stall_len, input string tag);
        logic [32:0] expq [$];
        logic [31:0] pa, pb, held_s;
        logic        psub;
        bit          stalled_prev;
        int          idx, got, t, first, last;
        idx = 0; got = 0; t = 0; first = -1; last = -1; stalled_prev = 0; held_s = '0;
        pa = $urandom; pb = $urandom; psub = 1'($urandom_range(0, 1));
        while (got < n && t < n + stall_len + 40) begin
            @(negedge clk);
            out_ready = !(t >= stall_at && t < stall_at + stall_len);
            in_valid = (idx < n); a = pa; b = pb; sub = psub;
            #1;
            if (!out_ready && out_valid) begin
                chk({tag, "_stall_in_ready"}, in_ready, 0);
                if (stalled_prev) chk({tag, "_stall_hold"}, s, held_s);
                held_s = s;
                stalled_prev = 1;
            end else begin
                stalled_prev = 0;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_add(pa, pb, psub));
                idx++;
                pa = $urandom; pb = $urandom; psub = 1'($urandom_range(0, 1));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk({tag, "_spurious"}, 1, 0);
                else chk({tag, "_result"}, {cout, s}, expq.pop_front());
                if (first < 0) first = t;
                last = t;
                got++;
            end
            t++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk({tag, "_count"}, got, n);
        chk({tag, "_leftover"}, expq.size(), 0);
        chk({tag, "_first_cycle"}, first, STAGES);
        if (stall_len == 0) chk({tag, "_throughput"}, last - first, n - 1);
        repeat (STAGES + 2) @(negedge clk);
        chk({tag, "_drain_idle"}, out_valid, 0);
    endtask

    initial begin
        int lat, stale;

        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'h0002_0000, 1'b0, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[9] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) one_xfer(vecs[i], $sformatf("vec%0d", i));

        run_stream(16, 0, 0, "stream");
        run_stream(8, 6, 5, "bp");

        // Three results in flight, the oldest stalled at the output, then a reset pulse.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 32'(i + 10); b = 32'h1; sub = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("flight_valid", out_valid, 1);
        chk("flight_s", s, 32'd11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_s", s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale", stale, 0);
        one_xfer(vecs[3], "post_rst");

        // 8-bit single stage: result one cycle after acceptance.
        @(negedge clk); v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0;
        @(negedge clk); v8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin @(negedge clk); lat++; end
        chk("d8_latency", lat, 1);
        chk("d8_s", s8, 8'h00);
        chk("d8_cout", c8, 1);
`ifdef PIPE_ADDER_OVF_EN
        chk("d8_ovf", ovf8, 0);
`endif
        @(negedge clk); v8 = 1'b1; a8 = 8'h00; b8 = 8'h01; sub8 = 1'b1;
        @(negedge clk); v8 = 1'b0;
        chk("d8_sub_s", s8, 8'hFF);
        chk("d8_sub_cout", c8, 0);
        chk("d8_ready", rdy8, 1);

        // 64-bit, eight stages.
        @(negedge clk); v64 = 1'b1; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h1; sub64 = 1'b0;
        @(negedge clk); v64 = 1'b1; a64 = 64'h0; b64 = 64'h1; sub64 = 1'b1;
        @(negedge clk); v64 = 1'b0;
        lat = 2;
        while (!ov64 && lat < 30) begin @(negedge clk); lat++; end
        chk("d64_latency", lat, 8);
        chk("d64_s", s64, 64'h0);
        chk("d64_cout", c64, 1);
`ifdef PIPE_ADDER_OVF_EN
        chk("d64_ovf", ovf64, 0);
`endif
        @(negedge clk);
        chk("d64_sub_valid", ov64, 1);
        chk("d64_sub_s", s64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("d64_sub_cout", c64, 0);
        chk("d64_ready", rdy64, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
